// File: rtl/dp_debug_pkg.sv
// rtl/dp_debug_pkg.sv - shared TAP state encoding, IR codes and DR select indices
package dp_debug_pkg;

    // Encoding follows the classic 1149.1 reference values, so tap_state can be
    // compared directly against other debug tooling.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    // Bit positions inside bsr_sel, shared with dp_mux_dr.
    localparam int SEL_IDCODE = 0;
    localparam int SEL_DTMCS  = 1;
    localparam int SEL_DMI    = 2;
    localparam int SEL_BYPASS = 3;
    localparam int SEL_W      = 4;

endpackage

// File: rtl/dp_tap_ctrl_if.sv
// rtl/dp_tap_ctrl_if.sv - TAP pin and DR-mux side signal bundle
//  master : TAP controller side (drives tdo, strobes, select, status)
//  slave  : pad/DR-mux side (drives tms, tdi, dr_sdo)
interface dp_tap_ctrl_if #(
    parameter int IR_W = 5
);
    logic            tms;
    logic            tdi;
    logic            dr_sdo;
    logic            tdo;
    logic            tdo_en;
    logic            capture_dr;
    logic            shift_dr;
    logic            clk_dr;
    logic            update_dr;
    logic [3:0]      bsr_sel;
    logic [IR_W-1:0] ir_q;
    logic [3:0]      tap_state;
    logic            tlr;

    modport master (
        input  tms, tdi, dr_sdo,
        output tdo, tdo_en, capture_dr, shift_dr, clk_dr, update_dr,
               bsr_sel, ir_q, tap_state, tlr
    );

    modport slave (
        output tms, tdi, dr_sdo,
        input  tdo, tdo_en, capture_dr, shift_dr, clk_dr, update_dr,
               bsr_sel, ir_q, tap_state, tlr
    );
endinterface

// File: rtl/dp_tap_fsm.sv
// rtl/dp_tap_fsm.sv - 16-state 1149.1 TAP state machine
//  tck   : TAP clock
//  trst  : synchronous active-high reset to TEST_LOGIC_RESET
//  tms   : test mode select
//  state : registered TAP state
module dp_tap_fsm
    import dp_debug_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        state_d = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst) state_q <= TEST_LOGIC_RESET;
        else      state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/dp_tap_ctrl.sv
// rtl/dp_tap_ctrl.sv - TAP controller: FSM, instruction register, DR select decode, tdo mux
//  tck, trst : TAP clock and synchronous active-high reset
//  tap       : master side of dp_tap_ctrl_if (tms/tdi/dr_sdo in; tdo, tdo_en,
//              DR strobes, bsr_sel, ir_q, tap_state, tlr out)
module dp_tap_ctrl
    import dp_debug_pkg::*;
#(
    parameter int              IR_W     = 5,
    parameter logic [IR_W-1:0] IR_RESET = IR_W'(5'h01)
) (
    input  logic          tck,
    input  logic          trst,
    dp_tap_ctrl_if.master tap
);

    tap_state_t      state;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [3:0]      bsr_sel;

    dp_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tap.tms),
        .state (state)
    );

    always_comb begin
        ir_sh_d = ir_sh_q;
        ir_d    = ir_q;
        unique case (state)
            CAPTURE_IR: ir_sh_d = IR_W'(1);
            SHIFT_IR:   ir_sh_d = {tap.tdi, ir_sh_q[IR_W-1:1]};
            UPDATE_IR:  ir_d    = ir_sh_q;
            default:    ;
        endcase
        // Load IDCODE on the edge that enters TEST_LOGIC_RESET (from SELECT_IR or
        // while parked there), so ir_q already reads IR_RESET during TLR itself.
        if (tap.tms && (state == SELECT_IR || state == TEST_LOGIC_RESET)) begin
            ir_d = IR_RESET;
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            ir_q    <= IR_RESET;
            ir_sh_q <= '0;
        end else begin
            ir_q    <= ir_d;
            ir_sh_q <= ir_sh_d;
        end
    end

    // Unknown codes fall to BYPASS so exactly one DR is always selected.
    always_comb begin
        bsr_sel = '0;
        if      (ir_q == IR_W'(IR_IDCODE)) bsr_sel[SEL_IDCODE] = 1'b1;
        else if (ir_q == IR_W'(IR_DTMCS))  bsr_sel[SEL_DTMCS]  = 1'b1;
        else if (ir_q == IR_W'(IR_DMI))    bsr_sel[SEL_DMI]    = 1'b1;
        else                               bsr_sel[SEL_BYPASS] = 1'b1;
    end

    assign tap.tdo        = (state == SHIFT_IR) ? ir_sh_q[0] :
                            (state == SHIFT_DR) ? tap.dr_sdo : 1'b0;
    assign tap.tdo_en     = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign tap.capture_dr = (state == CAPTURE_DR);
    assign tap.shift_dr   = (state == SHIFT_DR);
    assign tap.clk_dr     = (state == CAPTURE_DR) || (state == SHIFT_DR);
    assign tap.update_dr  = (state == UPDATE_DR);
    assign tap.bsr_sel    = bsr_sel;
    assign tap.ir_q       = ir_q;
    assign tap.tap_state  = state;
    assign tap.tlr        = (state == TEST_LOGIC_RESET);

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// tb/tb_dp_tap_ctrl.sv - self-checking bench for dp_tap_ctrl against a table-driven TAP model
module tb_dp_tap_ctrl;
    import dp_debug_pkg::*;

    logic tck  = 1'b0;
    logic trst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    dp_tap_ctrl_if #(.IR_W(5)) tif ();

    dp_tap_ctrl #(.IR_W(5), .IR_RESET(5'h01)) u_dut (
        .tck  (tck),
        .trst (trst),
        .tap  (tif)
    );

    always #5 tck = ~tck;

    // Reference model
    tap_state_t nt [0:15][0:1];
    tap_state_t m_state;
    logic [4:0] m_ir;
    logic [4:0] m_sh;

    task automatic set_nt(input tap_state_t s, input tap_state_t n0, input tap_state_t n1);
        nt[int'(s)][0] = n0;
        nt[int'(s)][1] = n1;
    endtask

    function automatic logic [3:0] exp_sel(input logic [4:0] ir);
        case (ir)
            5'h01:   return 4'b0001;
            5'h10:   return 4'b0010;
            5'h11:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic t_tms, input logic t_tdi, input logic t_trst);
        if (t_trst) begin
            m_state = TEST_LOGIC_RESET;
            m_ir    = 5'h01;
            m_sh    = 5'h00;
        end else begin
            if (m_state == CAPTURE_IR) m_sh = 5'h01;
            if (m_state == SHIFT_IR)   m_sh = (m_sh >> 1) | (5'(t_tdi) << 4);
            if (m_state == UPDATE_IR)  m_ir = m_sh;
            m_state = nt[int'(m_state)][t_tms];
            if (m_state == TEST_LOGIC_RESET) m_ir = 5'h01;
        end
    endtask

    task automatic check_all();
        logic in_shd;
        in_shd = (m_state == SHIFT_DR);
        check_eq("state",      32'(tif.tap_state),  32'(m_state));
        check_eq("ir_q",       32'(tif.ir_q),       32'(m_ir));
        check_eq("bsr_sel",    32'(tif.bsr_sel),    32'(exp_sel(m_ir)));
        check_eq("tlr",        32'(tif.tlr),        32'(m_state == TEST_LOGIC_RESET));
        check_eq("tdo_en",     32'(tif.tdo_en),     32'(m_state == SHIFT_IR || in_shd));
        check_eq("capture_dr", 32'(tif.capture_dr), 32'(m_state == CAPTURE_DR));
        check_eq("shift_dr",   32'(tif.shift_dr),   32'(in_shd));
        check_eq("clk_dr",     32'(tif.clk_dr),     32'(m_state == CAPTURE_DR || in_shd));
        check_eq("update_dr",  32'(tif.update_dr),  32'(m_state == UPDATE_DR));
        check_eq("tdo",        32'(tif.tdo),
                 32'((m_state == SHIFT_IR) ? m_sh[0] : in_shd ? tif.dr_sdo : 1'b0));
    endtask

    task automatic step(input logic t_tms, input logic t_tdi, input logic t_trst);
        tif.tms    = t_tms;
        tif.tdi    = t_tdi;
        trst       = t_trst;
        tif.dr_sdo = 1'($urandom_range(0, 1));
        @(posedge tck);
        model_edge(t_tms, t_tdi, t_trst);
        #1;
        check_all();
    endtask

    task automatic goto_rti();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // From RTI: load v into the IR (LSB first) and return to RTI; cap holds tdo seen in SH_IR.
    task automatic ir_scan(input logic [4:0] v, output logic [4:0] cap);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cap[i] = tif.tdo;
            step(1'(i == 4), v[i], 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] cap;
        logic [4:0] ir_before;
        int cnt_cap, cnt_sh, cnt_upd;

        set_nt(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
        set_nt(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR);
        set_nt(SELECT_DR,        CAPTURE_DR,    SELECT_IR);
        set_nt(SELECT_IR,        CAPTURE_IR,    TEST_LOGIC_RESET);
        set_nt(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
        set_nt(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
        set_nt(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
        set_nt(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
        set_nt(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
        set_nt(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR);
        set_nt(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
        set_nt(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
        set_nt(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
        set_nt(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
        set_nt(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
        set_nt(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR);
        m_state = TEST_LOGIC_RESET;
        m_ir    = 5'h01;
        m_sh    = 5'h00;

        // 1. reset, then leave TLR
        step(1'b1, 1'b1, 1'b1);
        check_eq("reset_tlr", 32'(tif.tlr), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("rti_after_reset", 32'(tif.tap_state), 32'(RUN_TEST_IDLE));
        check_eq("rti_sel", 32'(tif.bsr_sel), 32'b0001);

        // 2. IR = DMI, captured pattern on tdo
        ir_scan(5'h11, cap);
        check_eq("ir_cap_tdo", 32'(cap), 32'h01);
        check_eq("dmi_sel", 32'(tif.bsr_sel), 32'b0100);

        // 3. unknown and zero codes select BYPASS
        ir_scan(5'h05, cap);
        check_eq("ir05_sel", 32'(tif.bsr_sel), 32'b1000);
        ir_scan(5'h00, cap);
        check_eq("ir00_sel", 32'(tif.bsr_sel), 32'b1000);

        // 4. 32-bit DR scan; strobe lengths, IR untouched
        ir_scan(5'h10, cap);
        ir_before = tif.ir_q;
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) begin
            step((i == 33 || i == 34) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cnt_cap += int'(tif.capture_dr);
            cnt_sh  += int'(tif.shift_dr);
            cnt_upd += int'(tif.update_dr);
        end
        check_eq("dr_cap_cnt", 32'(cnt_cap), 32'd1);
        check_eq("dr_shift_cnt", 32'(cnt_sh), 32'd32);
        check_eq("dr_upd_cnt", 32'(cnt_upd), 32'd1);
        check_eq("dr_ir_kept", 32'(tif.ir_q), 32'(ir_before));
        check_eq("dr_end_rti", 32'(tif.tap_state), 32'(RUN_TEST_IDLE));

        // 5a. tms=1 x5 from mid SH_IR
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("tms5_state", 32'(tif.tap_state), 32'(TEST_LOGIC_RESET));
        check_eq("tms5_ir", 32'(tif.ir_q), 32'h01);
        check_eq("tms5_sel", 32'(tif.bsr_sel), 32'b0001);

        // 5b. trst mid SH_DR
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("trst_state", 32'(tif.tap_state), 32'(TEST_LOGIC_RESET));
        check_eq("trst_strobes", 32'({tif.capture_dr, tif.shift_dr, tif.clk_dr, tif.update_dr, tif.tdo_en}), 32'd0);

        // 6. IR scan with pause: tdi 1,1 | pause | 0,0,1 -> 5'h13
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("pause_resume_state", 32'(tif.tap_state), 32'(SHIFT_IR));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq("pause_ir_held", 32'(tif.ir_q), 32'h01);
        step(1'b0, 1'b0, 1'b0);
        check_eq("pause_ir", 32'(tif.ir_q), 32'h13);
        check_eq("pause_sel", 32'(tif.bsr_sel), 32'b1000);

        // Random walk, occasional reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 59) == 0));
        end
        goto_rti();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
